// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and bubble constant for the pipeline stage register
package pipe_pkg;
    localparam int DATA_W_DEF = 96;
    localparam int CTRL_W_DEF = 9;
    localparam int CNT_W_DEF = 16;
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid bit plus payload register with load and clear
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q <= d;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush and stall counter; PIPE_SKID_EN adds a skid slot
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int W = DATA_W + CTRL_W;
    logic         m_valid, m_load, m_clear, leave, accept;
    logic [W-1:0] m_d, m_q;
    assign leave = m_valid & out_ready;
    assign accept = in_valid & in_ready;
`ifdef PIPE_SKID_EN
    logic         s_valid, s_load, s_clear;
    logic [W-1:0] s_q;
    assign in_ready = ~s_valid & ~flush & ~reset;
    // skid is only ever full while main is full, so it refills main first on leave
    assign m_load = (accept & (~m_valid | leave)) | (leave & s_valid);
    assign m_d = s_valid ? s_q : {in_data, in_ctrl};
    assign m_clear = flush | (leave & ~m_load);
    assign s_load = accept & m_valid & ~leave;
    assign s_clear = flush | (leave & s_valid);
    pipe_slot #(.W(W)) u_skid (
        .clk(clk), .reset(reset), .load(s_load), .clear(s_clear),
        .d({in_data, in_ctrl}), .valid(s_valid), .q(s_q)
    );
`else
    assign in_ready = ~reset & ~flush & (out_ready | ~m_valid);
    assign m_load = accept;
    assign m_d = {in_data, in_ctrl};
    assign m_clear = flush | (leave & ~accept);
`endif
    pipe_slot #(.W(W)) u_main (
        .clk(clk), .reset(reset), .load(m_load), .clear(m_clear),
        .d(m_d), .valid(m_valid), .q(m_q)
    );
    assign out_valid = m_valid;
    assign out_data = m_q[W-1:CTRL_W];
    assign out_ctrl = m_valid ? m_q[CTRL_W-1:0] : CTRL_W'(CTRL_BUBBLE);
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (m_valid & ~out_ready & ~&stall_cnt)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule
